wb_ctrl: RTL

Writeback controller of the 4-stage pipeline: the producer end of the forwarding path. It accepts one completed instruction per cycle from EX and drives the register-file write port. It publishes the in-flight destination, data and valid flag that the forwarding comparator matches against the current sources. For loads it waits for the data-memory response and stalls EX meanwhile, with a bounded wait.

---
 rtl/wb_ctrl_pkg.sv | 22 ++
 rtl/wb_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared pipeline package for the writeback stage.
//   DATA_W      : datapath width
//   REG_AW      : register address width
//   wb_state_t  : writeback controller state
//   wb_bundle_t : register-file write bundle, reused for the forwarding port
package wb_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_bundle_t;

endpackage

// File: rtl/wb_ctrl.sv
// Writeback controller: producer end of the forwarding path.
// Accepts one completed instruction per cycle from EX, drives the register
// file write port and publishes the same write as the forwarding source.
// Loads stall EX until the memory response arrives or the wait times out.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   ex_valid / ex_ready       EX handshake; ex_ready is a decode of state only
//   ex_wen, ex_is_load        instruction writes a register / result from memory
//   ex_dst, ex_result         destination and ALU result
//   flush                     kill the pending instruction (wins over all else)
//   mem_rvalid, mem_rdata     load response
//   rf_we, rf_waddr, rf_wdata register-file write port (registered)
//   fwd_valid/dst/data        forwarding source, always identical to rf_*
//   err                       one-cycle pulse: load timeout or stray response
//   dbg_state                 current controller state
//
// Handshake: an instruction transfers on a rising edge where
// ex_valid & ex_ready & !flush; ex_ready never depends on ex_valid.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              flush,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dst,
  output logic [DATA_W-1:0] fwd_data,
  output logic              err,
  output wb_state_t         dbg_state
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOAD_TIMEOUT);

  wb_state_t         r_state,  w_state_nx;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nx;
  logic [REG_AW-1:0] r_ld_dst, w_ld_dst_nx;
  wb_bundle_t        r_wb,     w_wb_nx;
  logic              r_err,    w_err_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ld_dst <= '0;
      r_wb     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_ld_dst <= w_ld_dst_nx;
      r_wb     <= w_wb_nx;
      r_err    <= w_err_nx;
    end
  end

  always_comb begin
    // Address/data hold when no write happens; only the enable drops.
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_ld_dst_nx = r_ld_dst;
    w_wb_nx     = r_wb;
    w_wb_nx.we  = 1'b0;
    w_err_nx    = 1'b0;
    ex_ready    = (r_state == IDLE);

    if (flush) begin
      // Drops any same-cycle instruction or load data, and raises no err.
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_rvalid) w_err_nx = 1'b1;
          if (ex_valid && ex_wen) begin
            if (ex_is_load) begin
              w_ld_dst_nx = ex_dst;
              w_cnt_nx    = '0;
              w_state_nx  = LOAD_WAIT;
            end else begin
              w_wb_nx.we   = 1'b1;
              w_wb_nx.addr = ex_dst;
              w_wb_nx.data = ex_result;
            end
          end
        end
        LOAD_WAIT: begin
          if (mem_rvalid) begin
            w_wb_nx.we   = 1'b1;
            w_wb_nx.addr = r_ld_dst;
            w_wb_nx.data = mem_rdata;
            w_state_nx   = IDLE;
            w_cnt_nx     = '0;
          end else if (r_cnt == CNT_MAX) begin
            w_err_nx   = 1'b1;
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  assign rf_we     = r_wb.we;
  assign rf_waddr  = r_wb.addr;
  assign rf_wdata  = r_wb.data;
  assign fwd_valid = r_wb.we;
  assign fwd_dst   = r_wb.addr;
  assign fwd_data  = r_wb.data;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
